muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle unsigned multiply/divide sequencer for the EX stage, alongside the single-cycle ALU.
//   Accepts MULTU/DIVU from the EX stage and runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles.
//   Holds the pipeline via stall and writes the HI/LO architectural registers on completion.
//   Also stalls MFHI/MFLO reads issued while an operation is in flight.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO are WIDTH bits each
//   CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      EX stage presents a mul/div op this cycle
//   op           in   2      00 = MULTU, 01 = DIVU, 1x = ignored (no start)
//   src_a        in   WIDTH  multiplicand / dividend
//   src_b        in   WIDTH  multiplier / divisor
//   hilo_rd      in   1      MFHI/MFLO in EX this cycle
//   stall        out  1      freeze IF/ID/EX (combinational)
//   busy         out  1      state != IDLE
//   done         out  1      one-cycle completion pulse
//   div_by_zero  out  1      sticky flag: last DIVU had src_b == 0
//   hi           out  WIDTH  HI register (product[2W-1:W] / remainder)
//   lo           out  WIDTH  LO register (product[W-1:0] / quotient)
// BEHAVIOUR
//   Reset (asynchronous, any state): state=IDLE; count=0; hi=lo=0; div_by_zero=0; done=0; busy=0.
//     Internal accumulators cleared. Any in-flight op is abandoned and HI/LO are not written.
//   FSM states: IDLE, MUL, DIV, DONE.
//   IDLE:
//     start & op==00 -> MUL; latch a, b; acc = 0; count = 0.
//     start & op==01 & b!=0 -> DIV; remainder = 0; quotient reg = a; count = 0.
//     start & op==01 & b==0 -> DONE; next hi=src_a, lo={WIDTH{1}}, div_by_zero=1.
//     op==1x -> stay in IDLE; no effect.
//   MUL: one iteration per clock.
//     If b[0], add a to the upper half of the product; shift the 2W product right 1; count++.
//     After WIDTH iterations -> DONE; {hi, lo} = 2W product.
//   DIV: one restoring step per clock.
//     Shift {rem, quo} left 1; trial = rem - b (WIDTH+1 bits).
//     If trial is non-negative: rem = trial and quotient LSB = 1; otherwise quotient LSB = 0.
//     After WIDTH iterations -> DONE; hi = rem, lo = quo.
//   div_by_zero: set as above; cleared when any valid op starts with b != 0.
//   DONE: done = 1 for exactly one cycle, then -> IDLE.
//     hi/lo are already updated (visible) in this cycle.
//   Latency: start sampled at edge E0; edges E1..EWIDTH perform the iterations.
//     FSM enters DONE at EWIDTH; done is high between EWIDTH and EWIDTH+1.
//     Back-to-back ops: next start is accepted in IDLE, the cycle after DONE.
//     Divide by zero: done is high in the cycle right after E0.
//   stall = (IDLE & start & op valid) | MUL | DIV | (busy & hilo_rd & !DONE).
//     stall is low in DONE, so a stalled MFHI/MFLO reads the new HI/LO there.
//   start while MUL/DIV/DONE: ignored; the EX stage is frozen by stall, so it re-presents the op.
//   Operands are latched at E0; src_a/src_b changes after E0 have no effect.
//   HI/LO change only at entry to DONE or on reset; they otherwise hold their value.
// TESTING
//   MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done at cycle 33; stall high cycles 0-32.
//   DIVU 100/7 -> lo=14, hi=2, div_by_zero=0; then DIVU 0x80000000/1 -> lo=0x80000000, hi=0.
//   DIVU 5/0 -> done on cycle 1; hi=5, lo=0xFFFFFFFF, div_by_zero=1; next MULTU 3*4 clears flag, lo=12.
//   Re-pulse start with different operands during MUL and assert hilo_rd mid-op -> result unchanged;
//     stall held until DONE, low in DONE.
//   Assert reset at iteration 10 of a MULTU -> next cycle: IDLE, hi=lo=0, busy=0, no done pulse.
//   op=2'b10 with start=1 -> stall=0, busy=0, state stays IDLE, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one step per clock, writing HI/LO on completion.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_rd,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state  | meaning
  // S_IDLE | waiting for a MULTU/DIVU
  // S_MUL  | shift-add iterations
  // S_DIV  | restoring divide iterations
  // S_DONE | one-cycle completion, HI/LO already updated
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
  logic [WIDTH-1:0] r_acc_hi, w_acc_hi_nxt;
  logic [WIDTH-1:0] r_acc_lo, w_acc_lo_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_dbz, w_dbz_nxt;

  logic             w_last;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_rem, w_div_quo;

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  // Multiply: acc_hi is the upper product half, acc_lo holds the shrinking multiplier.
  assign w_mul_sum = {1'b0, r_acc_hi} + ({1'b0, r_opnd} & {(WIDTH+1){r_acc_lo[0]}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

  // Divide: acc_hi is the remainder, acc_lo the dividend shifting into the quotient.
  // The shifted remainder needs one extra bit; once accepted, the result always fits WIDTH bits.
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_rem   = w_div_ok ? (w_div_shift[WIDTH-1:0] - r_opnd) : w_div_shift[WIDTH-1:0];
  assign w_div_quo   = {r_acc_lo[WIDTH-2:0], w_div_ok};

  always_comb begin
    w_state_nxt  = r_state;
    w_opnd_nxt   = r_opnd;
    w_acc_hi_nxt = r_acc_hi;
    w_acc_lo_nxt = r_acc_lo;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_count_nxt  = r_count;
    w_dbz_nxt    = r_dbz;
    case (r_state)
      S_IDLE: begin
        if (start && op == 2'b00) begin
          w_state_nxt  = S_MUL;
          w_opnd_nxt   = src_a;
          w_acc_hi_nxt = '0;
          w_acc_lo_nxt = src_b;
          w_count_nxt  = '0;
          if (src_b != '0) w_dbz_nxt = 1'b0;
        end else if (start && op == 2'b01) begin
          if (src_b != '0) begin
            w_state_nxt  = S_DIV;
            w_opnd_nxt   = src_b;
            w_acc_hi_nxt = '0;
            w_acc_lo_nxt = src_a;
            w_count_nxt  = '0;
            w_dbz_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_DONE;
            w_hi_nxt    = src_a;
            w_lo_nxt    = '1;
            w_dbz_nxt   = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_acc_hi_nxt = w_mul_hi;
        w_acc_lo_nxt = w_mul_lo;
        w_count_nxt  = r_count + 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_hi_nxt    = w_mul_hi;
          w_lo_nxt    = w_mul_lo;
        end
      end
      S_DIV: begin
        w_acc_hi_nxt = w_div_rem;
        w_acc_lo_nxt = w_div_quo;
        w_count_nxt  = r_count + 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_hi_nxt    = w_div_rem;
          w_lo_nxt    = w_div_quo;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_opnd   <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_count  <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_opnd   <= w_opnd_nxt;
      r_acc_hi <= w_acc_hi_nxt;
      r_acc_lo <= w_acc_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_count  <= w_count_nxt;
      r_dbz    <= w_dbz_nxt;
    end
  end

  // Stall drops in DONE so a held MFHI/MFLO reads the fresh HI/LO there.
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign stall = ((r_state == S_IDLE) && start && !op[1])
               || (r_state == S_MUL) || (r_state == S_DIV)
               || (busy && hilo_rd && (r_state != S_DONE));

  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
